// File: rtl/z80_io_ctrl.sv
// Z80 I/O-cycle sequencer: synchronises the bus strobes, owns the four memory
// page registers and sequences 16550 accesses with chip select and a WAIT stretch.
module z80_io_ctrl #(
    parameter logic [7:0]  PAGE_BASE = 8'h10,
    parameter logic [7:0]  UART_BASE = 8'hF8,
    parameter int unsigned UART_WAIT = 3
) (
    input  logic       i_CLK_24MHz,
    input  logic       i_RES,
    input  logic       i_IORQ,
    input  logic       i_RD,
    input  logic       i_WR,
    input  logic       i_M1,
    input  logic [7:0] i_A,
    input  logic [7:0] i_D_in,
    output logic [7:0] o_D_out,
    output logic       o_D_oe,
    output logic       o_WAIT,
    output logic       o_U_CS,
    output logic [4:0] o_PAGE0,
    output logic [4:0] o_PAGE1,
    output logic [4:0] o_PAGE2,
    output logic [4:0] o_PAGE3
);

    localparam logic [3:0] LP_WAIT = 4'(UART_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_PAGE_WR,
        ST_PAGE_RD,
        ST_UART_ACC,
        ST_HOLD
    } state_t;

    state_t     r_state;
    logic [1:0] r_iorqSync;
    logic [1:0] r_rdSync;
    logic [1:0] r_wrSync;
    logic [1:0] r_m1Sync;
    logic [4:0] r_page [4];
    logic [1:0] r_sel;
    logic [4:0] r_wrData;
    logic [3:0] r_waitCnt;
    logic [7:0] r_dOut;
    logic       r_dOe;
    logic       r_waitN;
    logic       r_uCsN;

    logic       w_iorqS;
    logic       w_rdS;
    logic       w_wrS;
    logic       w_m1S;
    logic       w_ioReq;
    logic       w_pageHit;
    logic       w_uartHit;
    logic       w_isWrite;
    logic       w_unusedDin;

    // Strobes are asynchronous to CLK_24MHz; presetting to 1 keeps them inactive out of reset.
    always_ff @(posedge i_CLK_24MHz or posedge i_RES) begin
        if (i_RES) begin
            r_iorqSync <= 2'b11;
            r_rdSync   <= 2'b11;
            r_wrSync   <= 2'b11;
            r_m1Sync   <= 2'b11;
        end else begin
            r_iorqSync <= {r_iorqSync[0], i_IORQ};
            r_rdSync   <= {r_rdSync[0], i_RD};
            r_wrSync   <= {r_wrSync[0], i_WR};
            r_m1Sync   <= {r_m1Sync[0], i_M1};
        end
    end

    assign w_iorqS     = r_iorqSync[1];
    assign w_rdS       = r_rdSync[1];
    assign w_wrS       = r_wrSync[1];
    assign w_m1S       = r_m1Sync[1];

    // Interrupt acknowledge (M1 low) and the illegal RD+WR combination never start an access.
    assign w_ioReq     = !w_iorqS && w_m1S && (!w_rdS ^ !w_wrS);
    assign w_pageHit   = (i_A[7:2] == PAGE_BASE[7:2]);
    assign w_uartHit   = (i_A[7:3] == UART_BASE[7:3]);
    assign w_isWrite   = !w_wrS;
    assign w_unusedDin = ^i_D_in[7:5];

    always_ff @(posedge i_CLK_24MHz or posedge i_RES) begin
        if (i_RES) begin
            r_state   <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_page[i] <= 5'(i);
            end
            r_sel     <= 2'd0;
            r_wrData  <= 5'd0;
            r_waitCnt <= 4'd0;
            r_dOut    <= 8'h00;
            r_dOe     <= 1'b0;
            r_waitN   <= 1'b1;
            r_uCsN    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ioReq) begin
                        r_state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    r_sel    <= i_A[1:0];
                    r_wrData <= i_D_in[4:0];
                    if (w_pageHit) begin
                        r_state <= w_isWrite ? ST_PAGE_WR : ST_PAGE_RD;
                    end else if (w_uartHit) begin
                        r_state   <= ST_UART_ACC;
                        r_waitCnt <= LP_WAIT;
                        r_uCsN    <= 1'b0;
                        r_waitN   <= 1'b0;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end

                ST_PAGE_WR: begin
                    r_page[r_sel] <= r_wrData;
                    r_state       <= ST_HOLD;
                end

                ST_PAGE_RD: begin
                    r_dOut  <= {3'b000, r_page[r_sel]};
                    r_dOe   <= 1'b1;
                    r_state <= ST_HOLD;
                end

                // WAIT went low on entry, so releasing at count 1 gives exactly UART_WAIT low clocks.
                ST_UART_ACC: begin
                    if (w_iorqS) begin
                        r_state <= ST_IDLE;
                        r_waitN <= 1'b1;
                        r_uCsN  <= 1'b1;
                    end else if (r_waitCnt <= 4'd1) begin
                        r_state <= ST_HOLD;
                        r_waitN <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (w_iorqS) begin
                        r_state <= ST_IDLE;
                        r_dOe   <= 1'b0;
                        r_uCsN  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_D_out = r_dOut;
    assign o_D_oe  = r_dOe;
    assign o_WAIT  = r_waitN;
    assign o_U_CS  = r_uCsN;
    assign o_PAGE0 = r_page[0];
    assign o_PAGE1 = r_page[1];
    assign o_PAGE2 = r_page[2];
    assign o_PAGE3 = r_page[3];

endmodule

// File: tb/tb_z80_io_ctrl.sv
// Scoreboard bench for z80_io_ctrl: stimulus pushes expected output changes
// (with the clock they must appear on); a monitor pops them as the DUT changes.
module tb_z80_io_ctrl;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  dOut;
        logic        dOe;
        logic        waitN;
        logic        uCsN;
        logic [4:0]  p0;
        logic [4:0]  p1;
        logic [4:0]  p2;
        logic [4:0]  p3;
    } obs_t;

    logic       clk = 1'b0;
    logic       res;
    logic       iorqN;
    logic       rdN;
    logic       wrN;
    logic       m1N;
    logic [7:0] addr;
    logic [7:0] dIn;
    logic [7:0] dOut;
    logic       dOe;
    logic       waitN;
    logic       uCsN;
    logic [4:0] page0;
    logic [4:0] page1;
    logic [4:0] page2;
    logic [4:0] page3;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    obs_t expQ[$];
    string nameQ[$];

    logic [4:0] mPage [4];
    logic [7:0] mDOut;
    logic       mDoe;
    logic       mWait;
    logic       mUcs;

    z80_io_ctrl #(
        .PAGE_BASE(8'h10),
        .UART_BASE(8'hF8),
        .UART_WAIT(3)
    ) dut (
        .i_CLK_24MHz(clk),
        .i_RES      (res),
        .i_IORQ     (iorqN),
        .i_RD       (rdN),
        .i_WR       (wrN),
        .i_M1       (m1N),
        .i_A        (addr),
        .i_D_in     (dIn),
        .o_D_out    (dOut),
        .o_D_oe     (dOe),
        .o_WAIT     (waitN),
        .o_U_CS     (uCsN),
        .o_PAGE0    (page0),
        .o_PAGE1    (page1),
        .o_PAGE2    (page2),
        .o_PAGE3    (page3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic obs_t sampleDut();
        obs_t o;
        o.cyc   = 32'(cyc);
        o.dOut  = dOut;
        o.dOe   = dOe;
        o.waitN = waitN;
        o.uCsN  = uCsN;
        o.p0    = page0;
        o.p1    = page1;
        o.p2    = page2;
        o.p3    = page3;
        return o;
    endfunction

    function automatic obs_t modelObs(input int c);
        obs_t o;
        o.cyc   = 32'(c);
        o.dOut  = mDOut;
        o.dOe   = mDoe;
        o.waitN = mWait;
        o.uCsN  = mUcs;
        o.p0    = mPage[0];
        o.p1    = mPage[1];
        o.p2    = mPage[2];
        o.p3    = mPage[3];
        return o;
    endfunction

    function automatic bit sameVals(input obs_t a, input obs_t b);
        return (a.dOut === b.dOut) && (a.dOe === b.dOe) && (a.waitN === b.waitN) &&
               (a.uCsN === b.uCsN) && (a.p0 === b.p0) && (a.p1 === b.p1) &&
               (a.p2 === b.p2) && (a.p3 === b.p3);
    endfunction

    function automatic void report(input string tag, input obs_t got, input obs_t req);
        $display("[TB] FAIL %s: got cyc=%0d dout=%h oe=%b wait=%b ucs=%b pages=%h/%h/%h/%h, required cyc=%0d dout=%h oe=%b wait=%b ucs=%b pages=%h/%h/%h/%h",
                 tag, got.cyc, got.dOut, got.dOe, got.waitN, got.uCsN, got.p0, got.p1, got.p2, got.p3,
                 req.cyc, req.dOut, req.dOe, req.waitN, req.uCsN, req.p0, req.p1, req.p2, req.p3);
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) mPage[i] = 5'(i);
        mDOut = 8'h00;
        mDoe  = 1'b0;
        mWait = 1'b1;
        mUcs  = 1'b1;
    endfunction

    function automatic void pushExp(input string name, input int c);
        expQ.push_back(modelObs(c));
        nameQ.push_back(name);
    endfunction

    // Every change on the DUT outputs must match the oldest outstanding expectation.
    initial begin : monitor
        obs_t  cur;
        obs_t  prev;
        obs_t  e;
        string nm;
        prev = '0;
        forever begin
            @(negedge clk or posedge res);
            if (res) #1;
            cur = sampleDut();
            if (!sameVals(cur, prev)) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    report("unexpected_change", cur, prev);
                end else begin
                    e  = expQ.pop_front();
                    nm = nameQ.pop_front();
                    if (cur !== e) begin
                        errors++;
                        report(nm, cur, e);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic applyStimulus(input logic rdL, input logic wrL, input logic m1L,
                                 input logic [7:0] a, input logic [7:0] d, output int c0);
        addr  = a;
        dIn   = d;
        rdN   = rdL;
        wrN   = wrL;
        m1N   = m1L;
        iorqN = 1'b0;
        c0    = cyc;
    endtask

    task automatic releaseBus(output int r0);
        iorqN = 1'b1;
        rdN   = 1'b1;
        wrN   = 1'b1;
        m1N   = 1'b1;
        r0    = cyc;
    endtask

    task automatic checkOutput(input string tag);
        obs_t cur;
        obs_t req;
        cur = sampleDut();
        req = modelObs(cyc);
        checks++;
        if (!sameVals(cur, req)) begin
            errors++;
            report(tag, cur, req);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: pending events %0d, required 0", tag, expQ.size());
            expQ.delete();
            nameQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int c0;
        int r0;
        res   = 1'b0;
        iorqN = 1'b1;
        rdN   = 1'b1;
        wrN   = 1'b1;
        m1N   = 1'b1;
        addr  = 8'h00;
        dIn   = 8'h00;
        modelReset();
        pushExp("reset_init", 0);
        #2 res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        drain("reset_init");
        checkOutput("idle_after_reset");

        // Page write: visible on the 5th clock after IORQ falls, no WAIT.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h01, c0);
        mPage[0] = 5'h01;
        pushExp("wr_page0", c0 + 5);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        drain("wr_page0");
        checkOutput("wr_page0_others");

        // Data changing mid-cycle must not cause a second write.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h11, 8'h11, c0);
        mPage[1] = 5'h11;
        pushExp("wr_page1", c0 + 5);
        repeat (7) @(negedge clk);
        dIn = 8'h22;
        repeat (6) @(negedge clk);
        releaseBus(r0);
        drain("wr_page1");
        checkOutput("wr_page1_single");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h12, 8'h00, c0);
        mDOut = 8'h02;
        mDoe  = 1'b1;
        pushExp("rd_page2", c0 + 5);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        mDoe = 1'b0;
        pushExp("rd_page2_release", r0 + 3);
        drain("rd_page2");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'hF9, 8'h00, c0);
        mWait = 1'b0;
        mUcs  = 1'b0;
        pushExp("uart_wait_low", c0 + 4);
        mWait = 1'b1;
        pushExp("uart_wait_high", c0 + 7);
        repeat (10) @(negedge clk);
        releaseBus(r0);
        mUcs = 1'b1;
        pushExp("uart_cs_release", r0 + 3);
        drain("uart_rd");

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 8'h07, c0);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        drain("inta");
        checkOutput("inta_null");

        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 8'h07, c0);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        drain("rdwr_both");
        checkOutput("rdwr_null");

        // Upper data bits are dropped.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h13, 8'hFF, c0);
        mPage[3] = 5'h1F;
        pushExp("wr_page3", c0 + 5);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        drain("wr_page3");

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h14, 8'h05, c0);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        drain("wr_0x14");
        checkOutput("wr_0x14_nodecode");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'hF7, 8'h00, c0);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        drain("rd_0xF7");
        checkOutput("rd_0xF7_nodecode");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11, 8'h00, c0);
        mDOut = 8'h11;
        mDoe  = 1'b1;
        pushExp("rd_page1", c0 + 5);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        mDoe = 1'b0;
        pushExp("rd_page1_release", r0 + 3);
        drain("rd_page1");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h13, 8'h00, c0);
        mDOut = 8'h1F;
        mDoe  = 1'b1;
        pushExp("rd_page3", c0 + 5);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        mDoe = 1'b0;
        pushExp("rd_page3_release", r0 + 3);
        drain("rd_page3");

        // IORQ withdrawn before WAIT would expire: abort drops WAIT and U_CS together.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, c0);
        mWait = 1'b0;
        mUcs  = 1'b0;
        pushExp("uart_abort_low", c0 + 4);
        repeat (3) @(negedge clk);
        releaseBus(r0);
        mWait = 1'b1;
        mUcs  = 1'b1;
        pushExp("uart_abort", c0 + 6);
        drain("uart_abort");
        checkOutput("after_abort");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'hF8, 8'h00, c0);
        mWait = 1'b0;
        mUcs  = 1'b0;
        pushExp("uart_rst_low", c0 + 4);
        repeat (5) @(negedge clk);
        modelReset();
        pushExp("reset_mid_uart", cyc);
        #2 res = 1'b1;
        @(negedge clk);
        releaseBus(r0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        drain("reset_mid_uart");
        checkOutput("after_reset");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h12, 8'h00, c0);
        mDOut = 8'h02;
        mDoe  = 1'b1;
        pushExp("rd_page2_post_reset", c0 + 5);
        repeat (8) @(negedge clk);
        releaseBus(r0);
        mDoe = 1'b0;
        pushExp("rd_page2_post_reset_release", r0 + 3);
        drain("rd_page2_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
